// File: rtl/conv_pool_relu_if.sv
// conv_pool_relu_if
// Stream bundle between the conv PE, the pooling stage and its consumer.
//   in_valid   : in_data carries a conv result this cycle
//   in_sof     : start of frame, qualifies in_valid, marks pixel (0,0)
//   in_data    : signed conv result, 2*WIDTH bits
//   out_valid  : one-cycle pulse, out_data valid
//   out_data   : signed pooled result, 2*WIDTH bits
//   frame_done : one-cycle pulse with the last pooled output of a frame
// master drives the input stream and observes the outputs; slave is the
// pooling stage itself.
interface conv_pool_relu_if #(
  parameter int WIDTH = 9
);
  logic                        in_valid;
  logic                        in_sof;
  logic signed [2*WIDTH-1:0]   in_data;
  logic                        out_valid;
  logic signed [2*WIDTH-1:0]   out_data;
  logic                        frame_done;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_data, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_data, frame_done
  );
endinterface

// File: rtl/conv_pool_relu.sv
// conv_pool_relu
// 2x2 stride-2 max-pooling of the raster-ordered conv result stream, with
// an optional ReLU in front of the pooling. One pooled value is emitted per
// 2x2 window; a half-row line buffer keeps the even-row pair maxima until
// the matching odd row arrives. No backpressure.
// Optional feature macro: POOL_RELU_EN (defined: negative inputs clamp to 0
// before pooling; undefined: pure signed max-pool).
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : synchronous reset, ACTIVE-HIGH (name kept for wiring compat)
//   bus   : conv_pool_relu_if.slave (in_valid/in_sof/in_data in,
//           out_valid/out_data/frame_done out, all outputs registered)
// Trailing odd column/row is counted but never pooled (floor semantics).
module conv_pool_relu #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_pool_relu_if.slave  bus
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW = IMG_W / 2;        // line buffer depth
  localparam int PW = 2 * (IMG_W / 2);  // pooled columns span
  localparam int PH = 2 * (IMG_H / 2);  // pooled rows span

  // Signed maximum of two data-path words.
  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic signed [DW-1:0]   h_max_q;
  logic signed [DW-1:0]   lbuf_q [0:HW-1];
  logic                   out_valid_q;
  logic signed [DW-1:0]   out_data_q;
  logic                   frame_done_q;

  logic [CW-1:0]          pix_c_s;
  logic [RW-1:0]          pix_r_s;
  logic [CW-1:0]          half_s;
  logic signed [DW-1:0]   p_s;
  logic signed [DW-1:0]   lbuf_rd_s;
  logic signed [DW-1:0]   h_pair_s;
  logic signed [DW-1:0]   win_max_s;
  logic                   in_win_s;
  logic                   h_we_s;
  logic                   lb_we_s;
  logic                   emit_s;
  logic                   last_s;

  // Pixel position, activation, next counters and pooling decisions.
  always_comb begin
    // in_sof forces the current pixel to (0,0) whatever the counters say,
    // which also discards any partial window of an aborted frame.
    if (bus.in_sof) begin
      pix_c_s = {CW{1'b0}};
      pix_r_s = {RW{1'b0}};
    end else begin
      pix_c_s = col_q;
      pix_r_s = row_q;
    end

`ifdef POOL_RELU_EN
    p_s = bus.in_data[DW-1] ? {DW{1'b0}} : bus.in_data;
`else
    p_s = bus.in_data;
`endif

    if (pix_c_s == CW'(IMG_W - 1)) begin
      col_d = {CW{1'b0}};
      if (pix_r_s == RW'(IMG_H - 1)) begin
        row_d = {RW{1'b0}};
      end else begin
        row_d = pix_r_s + RW'(1);
      end
    end else begin
      col_d = pix_c_s + CW'(1);
      row_d = pix_r_s;
    end

    half_s    = pix_c_s >> 1;
    lbuf_rd_s = lbuf_q[0];
    for (int i = 1; i < HW; i++) begin
      lbuf_rd_s = (half_s == CW'(i)) ? lbuf_q[i] : lbuf_rd_s;
    end

    h_pair_s  = smax(h_max_q, p_s);
    win_max_s = smax(lbuf_rd_s, h_pair_s);

    // Trailing odd column/row falls outside the pooled region.
    in_win_s = (32'(pix_c_s) < 32'(PW)) && (32'(pix_r_s) < 32'(PH));
    h_we_s   = bus.in_valid && in_win_s && !pix_c_s[0];
    lb_we_s  = bus.in_valid && in_win_s &&  pix_c_s[0] && !pix_r_s[0];
    emit_s   = bus.in_valid && in_win_s &&  pix_c_s[0] &&  pix_r_s[0];
    last_s   = (pix_c_s == CW'(PW - 1)) && (pix_r_s == RW'(PH - 1));
  end

  // Counters, horizontal partial max, line buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      h_max_q      <= {DW{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {DW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= emit_s;
      frame_done_q <= emit_s && last_s;
      if (emit_s) begin
        out_data_q <= win_max_s;
      end
      if (bus.in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (h_we_s) begin
        h_max_q <= p_s;
      end
      // The line buffer is never cleared: every entry is written on an
      // even row before the odd row reads it.
      for (int i = 0; i < HW; i++) begin
        if (lb_we_s && (half_s == CW'(i))) begin
          lbuf_q[i] <= h_pair_s;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_pool_relu.sv
// tb_conv_pool_relu
// Drives a 4x4 and a 5x5 instance of conv_pool_relu and compares every
// cycle's outputs against a frame-level reference that stores the pixels
// of the current frame and pools each complete 2x2 window directly.
`timescale 1ns/1ps
module tb_conv_pool_relu;

  localparam int WIDTH = 9;
  localparam int DW    = 2 * WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  conv_pool_relu_if #(.WIDTH(WIDTH)) bus4 ();
  conv_pool_relu_if #(.WIDTH(WIDTH)) bus5 ();

  conv_pool_relu #(.WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  conv_pool_relu #(.WIDTH(WIDTH), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: pixel index within the frame and the frame image.
  int                    kpos   [2];
  logic signed [DW-1:0]  img    [2][64];
  logic signed [DW-1:0]  last_d [2];
  bit                    need_sof [2];

  function automatic int img_w(input int dut);
    return (dut == 0) ? 4 : 5;
  endfunction

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef POOL_RELU_EN
    return (v < DW'(0)) ? DW'(0) : v;
`else
    return v;
`endif
  endfunction

  // Accept one pixel into the reference; report the expected pulse.
  task automatic model_accept(input int dut, input bit sof,
                              input logic signed [DW-1:0] d,
                              output bit ev, output logic signed [DW-1:0] ed,
                              output bit efd);
    int w, r, c;
    logic signed [DW-1:0] m;
    w = img_w(dut);
    if (sof) kpos[dut] = 0;
    r = kpos[dut] / w;
    c = kpos[dut] % w;
    img[dut][r*8 + c] = relu(d);
    ev  = 1'b0;
    efd = 1'b0;
    ed  = DW'(0);
    if ((r % 2 == 1) && (c % 2 == 1) && (r < 2*(w/2)) && (c < 2*(w/2))) begin
      m = img[dut][(r-1)*8 + (c-1)];
      if (img[dut][(r-1)*8 + c] > m) m = img[dut][(r-1)*8 + c];
      if (img[dut][r*8 + (c-1)] > m) m = img[dut][r*8 + (c-1)];
      if (img[dut][r*8 + c] > m)     m = img[dut][r*8 + c];
      ev  = 1'b1;
      ed  = m;
      efd = (r == 2*(w/2) - 1) && (c == 2*(w/2) - 1);
    end
    kpos[dut] = (kpos[dut] + 1) % (w * w);
  endtask

  task automatic drive(input int dut, input logic v, input logic s,
                       input logic signed [DW-1:0] d);
    if (dut == 0) begin
      bus4.in_valid = v; bus4.in_sof = s; bus4.in_data = d;
    end else begin
      bus5.in_valid = v; bus5.in_sof = s; bus5.in_data = d;
    end
  endtask

  task automatic check_dut(input int dut, input bit ev, input bit efd);
    if (dut == 0) begin
      check_eq("valid4", 32'(bus4.out_valid), 32'(ev));
      check_eq("done4",  32'(bus4.frame_done), 32'(efd));
      check_eq("data4",  32'(bus4.out_data), 32'(last_d[0]));
    end else begin
      check_eq("valid5", 32'(bus5.out_valid), 32'(ev));
      check_eq("done5",  32'(bus5.frame_done), 32'(efd));
      check_eq("data5",  32'(bus5.out_data), 32'(last_d[1]));
    end
  endtask

  // One accepted pixel; outputs checked #1 after the accepting edge.
  task automatic px(input int dut, input bit sof, input logic signed [DW-1:0] d);
    bit ev, efd;
    logic signed [DW-1:0] ed;
    drive(dut, 1'b1, sof, d);
    model_accept(dut, sof, d, ev, ed, efd);
    @(posedge clk); #1;
    drive(dut, 1'b0, 1'b0, DW'(0));
    if (ev) last_d[dut] = ed;
    check_dut(dut, ev, efd);
    check_dut(1 - dut, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_dut(0, 1'b0, 1'b0);
      check_dut(1, 1'b0, 1'b0);
    end
  endtask

  // One-cycle reset, optionally with a pixel offered in the same cycle.
  task automatic do_reset(input bit with_px);
    rst_n = 1'b1;
    drive(0, with_px, 1'b0, DW'(11));
    drive(1, with_px, 1'b0, DW'(11));
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, DW'(0));
    drive(1, 1'b0, 1'b0, DW'(0));
    for (int i = 0; i < 2; i++) begin
      kpos[i]     = 0;
      last_d[i]   = DW'(0);
      need_sof[i] = 1'b0;
    end
    check_dut(0, 1'b0, 1'b0);
    check_dut(1, 1'b0, 1'b0);
  endtask

  // kind: 0 ramp 1..N, 1 all -5, 2 mixed first window, 3 random.
  // gap < 0 selects a random 0..3 idle gap after each pixel.
  task automatic frame(input int dut, input bit sof, input int kind,
                       input int gap, input int npix);
    logic signed [DW-1:0] d;
    logic [31:0] u;
    for (int k = 0; k < npix; k++) begin
      u = $urandom;
      case (kind)
        0: d = DW'(k + 1);
        1: d = DW'(-5);
        2: begin
          case (k)
            0:       d = DW'(-3);
            1:       d = DW'(2);
            4:       d = DW'(-7);
            5:       d = DW'(-1);
            default: d = {{(DW-4){u[3]}}, u[3:0]};
          endcase
        end
        default: d = u[DW-1:0];
      endcase
      px(dut, sof && (k == 0), d);
      if (gap < 0) idle($urandom_range(0, 3));
      else         idle(gap);
    end
  endtask

  initial begin
    int dut, n;
    bit abort, sof;
    drive(0, 1'b0, 1'b0, DW'(0));
    drive(1, 1'b0, 1'b0, DW'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    idle(2);

    // Ramp frame, continuous valid.
    frame(0, 1'b1, 0, 0, 16);
    idle(2);
    // All-negative frame, then a mixed first window.
    frame(0, 1'b1, 1, 0, 16);
    frame(0, 1'b1, 2, 0, 16);
    // Ramp with 3 idle cycles after every pixel.
    frame(0, 1'b1, 0, 3, 16);
    // Abort after 6 pixels, restart with in_sof.
    frame(0, 1'b1, 0, 0, 6);
    frame(0, 1'b1, 0, 0, 16);
    // Reset after pixel 10, coincident with a valid pixel that is dropped.
    frame(0, 1'b1, 0, 0, 10);
    do_reset(1'b1);
    idle(1);
    frame(0, 1'b0, 0, 0, 16);
    // Odd image size, then a second frame that wraps without in_sof.
    frame(1, 1'b1, 0, 0, 25);
    frame(1, 1'b0, 0, 1, 25);
    // in_sof without in_valid is ignored.
    bus4.in_sof = 1'b1;
    idle(1);
    bus4.in_sof = 1'b0;

    // Random frames, random gaps, occasional aborts.
    for (int f = 0; f < 12; f++) begin
      dut   = $urandom_range(0, 1);
      n     = img_w(dut) * img_w(dut);
      abort = ($urandom_range(0, 3) == 0);
      if (abort) n = $urandom_range(1, n - 1);
      sof   = need_sof[dut] || ($urandom_range(0, 1) == 1);
      if (kpos[dut] != 0) sof = 1'b1;
      frame(dut, sof, 3, -1, n);
      need_sof[dut] = abort;
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
